// File: rtl/serial_pkg.sv
// Shared types and line constants for the serial UART bridge.
package serial_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int unsigned FRAME_DATA_BITS = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide first-word fall-through FIFO; simultaneous push and pop both take effect.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same edge, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// CPU byte port to 8N1 UART bridge with TX/RX FIFOs.
// Optional SERIAL_LOOPBACK_EN feeds the registered TX line back into the RX synchronizer.
module serial_uart_bridge
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_wdata_in,
    input  logic       cpu_wren_in,
    input  logic       cpu_rden_in,
    output logic [7:0] cpu_rdata_out,
    output logic       cpu_valid_out,
    output logic       cpu_ready_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overflow_out,
    output logic       rx_frame_err_out
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(FRAME_DATA_BITS - 1);

    logic [7:0]       tx_rdata;
    logic [CNT_W-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_pop;
    logic [7:0]       rx_rdata;
    logic [CNT_W-1:0] rx_count;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cpu_wren_in),
        .pop   (tx_pop),
        .wdata (cpu_wdata_in),
        .rdata (tx_rdata),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    tx_state_t         tx_state, tx_state_next;
    logic [BAUD_W-1:0] tx_baud, tx_baud_next;
    logic [2:0]        tx_idx, tx_idx_next;
    logic [7:0]        tx_shift, tx_shift_next;
    logic              tx_line, tx_line_next;
    logic [7:0]        rx_shift, rx_shift_next;

    assign cpu_ready_out = (tx_count != CNT_W'(FIFO_DEPTH));
    assign cpu_valid_out = (rx_count != '0);
    assign cpu_rdata_out = rx_rdata;
    assign uart_tx_out   = tx_line;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_line  <= LINE_IDLE;
        end else begin
            tx_state <= tx_state_next;
            tx_baud  <= tx_baud_next;
            tx_idx   <= tx_idx_next;
            tx_shift <= tx_shift_next;
            tx_line  <= tx_line_next;
        end
    end

    // TX next state: the line level for the coming bit is registered on each bit boundary.
    always_comb begin
        tx_state_next = tx_state;
        tx_baud_next  = tx_baud;
        tx_idx_next   = tx_idx;
        tx_shift_next = tx_shift;
        tx_line_next  = tx_line;
        tx_pop        = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_line_next = LINE_IDLE;
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = tx_rdata;
                    tx_baud_next  = '0;
                    tx_line_next  = LINE_START;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_baud == BIT_LAST) begin
                    tx_baud_next  = '0;
                    tx_idx_next   = '0;
                    tx_line_next  = tx_shift[0];
                    tx_state_next = TX_DATA;
                end else begin
                    tx_baud_next = tx_baud + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_baud == BIT_LAST) begin
                    tx_baud_next = '0;
                    if (tx_idx == IDX_LAST) begin
                        tx_line_next  = LINE_STOP;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_idx_next   = tx_idx + 3'(1);
                        tx_shift_next = tx_shift >> 1;
                        tx_line_next  = tx_shift[1];
                    end
                end else begin
                    tx_baud_next = tx_baud + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_baud == BIT_LAST) begin
                    tx_baud_next = '0;
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = tx_rdata;
                        tx_line_next  = LINE_START;
                        tx_state_next = TX_START;
                    end else begin
                        tx_line_next  = LINE_IDLE;
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_baud_next = tx_baud + BAUD_W'(1);
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    logic rx_src;
    logic rx_meta;
    logic rx_sync;

`ifdef SERIAL_LOOPBACK_EN
    assign rx_src = tx_line;
    logic unused_rx_pin;
    assign unused_rx_pin = uart_rx_in;
`else
    assign rx_src = uart_rx_in;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= LINE_IDLE;
            rx_sync <= LINE_IDLE;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
        end
    end

    rx_state_t         rx_state, rx_state_next;
    logic [BAUD_W-1:0] rx_baud, rx_baud_next;
    logic [2:0]        rx_idx, rx_idx_next;
    logic              rx_ferr_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_baud  <= rx_baud_next;
            rx_idx   <= rx_idx_next;
            rx_shift <= rx_shift_next;
        end
    end

    // RX next state: START re-checks at half a bit, later samples land mid-bit.
    always_comb begin
        rx_state_next = rx_state;
        rx_baud_next  = rx_baud;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        rx_push       = 1'b0;
        rx_ferr_set   = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_sync == LINE_START) begin
                    rx_baud_next  = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_baud == HALF_LAST) begin
                    rx_baud_next  = '0;
                    rx_idx_next   = '0;
                    rx_state_next = (rx_sync == LINE_START) ? RX_DATA : RX_IDLE;
                end else begin
                    rx_baud_next = rx_baud + BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_baud == BIT_LAST) begin
                    rx_baud_next  = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    if (rx_idx == IDX_LAST) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_idx_next = rx_idx + 3'(1);
                    end
                end else begin
                    rx_baud_next = rx_baud + BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_baud == BIT_LAST) begin
                    rx_baud_next  = '0;
                    rx_state_next = RX_IDLE;
                    if (rx_sync == LINE_STOP) begin
                        rx_push = 1'b1;
                    end else begin
                        rx_ferr_set = 1'b1;
                    end
                end else begin
                    rx_baud_next = rx_baud + BAUD_W'(1);
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (cpu_rden_in),
        .wdata (rx_shift),
        .rdata (rx_rdata),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // A byte is only lost when the FIFO is full and the CPU is not popping that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_overflow_out  <= 1'b0;
            rx_frame_err_out <= 1'b0;
        end else begin
            if (rx_push && rx_full && !cpu_rden_in) begin
                rx_overflow_out <= 1'b1;
            end
            if (rx_ferr_set) begin
                rx_frame_err_out <= 1'b1;
            end
        end
    end

    logic [1:0] unused_fifo_status;
    assign unused_fifo_status = {tx_full, rx_empty};

endmodule
